// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WIDTH_W = 2;

  // Bit positions of the two requesters in req/gnt vectors.
  localparam int unsigned IDX_I = 0;
  localparam int unsigned IDX_D = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam logic [WIDTH_W-1:0] WIDTH_BYTE = 2'b00;
  localparam logic [WIDTH_W-1:0] WIDTH_HALF = 2'b01;
  localparam logic [WIDTH_W-1:0] WIDTH_WORD = 2'b10;

  // Command presented on the shared memory port.
  typedef struct packed {
    logic               we;
    logic [WIDTH_W-1:0] width;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic               if_req;
  logic [ADDR_W-1:0]  if_addr;
  logic [DATA_W-1:0]  if_rdata;
  logic               if_valid;

  logic               d_req;
  logic               d_we;
  logic [WIDTH_W-1:0] d_width;
  logic [ADDR_W-1:0]  d_addr;
  logic [DATA_W-1:0]  d_wdata;
  logic [DATA_W-1:0]  d_rdata;
  logic               d_valid;

  logic               m_req;
  logic               m_we;
  logic [WIDTH_W-1:0] m_width;
  logic [ADDR_W-1:0]  m_addr;
  logic [DATA_W-1:0]  m_wdata;
  logic [DATA_W-1:0]  m_rdata;
  logic               m_ready;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_width, d_addr, d_wdata, m_rdata, m_ready,
    output if_rdata, if_valid, d_rdata, d_valid, m_req, m_we, m_width, m_addr, m_wdata
  );

  // Requesters and memory side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_width, d_addr, d_wdata, m_rdata, m_ready,
    input  if_rdata, if_valid, d_rdata, d_valid, m_req, m_we, m_width, m_addr, m_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the port not granted last wins.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last_grant,
  output logic [1:0] gnt
);

  // One-hot grant; a single requester always wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant == GNT_D) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              m_req_q, m_req_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;

  logic [1:0] req;
  logic [1:0] gnt;

  assign req = {bus.d_req, bus.if_req};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    m_req_d      = m_req_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt[IDX_I]) begin
          state_d     = BUSY_I;
          m_req_d     = 1'b1;
          cmd_d.we    = 1'b0;
          cmd_d.width = WIDTH_WORD;
          cmd_d.addr  = bus.if_addr;
        end else if (gnt[IDX_D]) begin
          state_d = BUSY_D;
          m_req_d = 1'b1;
          cmd_d   = '{we: bus.d_we, width: bus.d_width, addr: bus.d_addr, wdata: bus.d_wdata};
        end
      end
      BUSY_I: begin
        if (bus.m_ready) begin
          state_d      = DONE;
          m_req_d      = 1'b0;
          if_rdata_d   = bus.m_rdata;
          if_valid_d   = 1'b1;
          last_grant_d = GNT_I;
        end
      end
      BUSY_D: begin
        if (bus.m_ready) begin
          state_d      = DONE;
          m_req_d      = 1'b0;
          cmd_d.we     = 1'b0;
          d_rdata_d    = bus.m_rdata;
          d_valid_d    = 1'b1;
          last_grant_d = GNT_D;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_D;
      cmd_q        <= '0;
      m_req_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      m_req_q      <= m_req_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
    end
  end

  assign bus.m_req    = m_req_q;
  assign bus.m_we     = cmd_q.we;
  assign bus.m_width  = cmd_q.width;
  assign bus.m_addr   = cmd_q.addr;
  assign bus.m_wdata  = cmd_q.wdata;
  assign bus.if_rdata = if_rdata_q;
  assign bus.if_valid = if_valid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_valid  = d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected commands and
// completions, monitors pop and compare as the DUT presents them.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    grant_t      port;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t     rsp_q[$];
  mem_cmd_t cmd_q[$];

  int checks   = 0;
  int failures = 0;
  int rsp_seen = 0;
  int resp_wait = 0;
  bit stray = 1'b0;
  logic [31:0] exp_wdata = 32'h0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Memory model: m_ready after resp_wait stalled cycles, or constantly when stray.
  initial begin : responder
    int cnt;
    cnt = 0;
    bus.m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stray) begin
        bus.m_ready = 1'b1;
      end else if (bus.m_req) begin
        if (cnt >= resp_wait) begin
          bus.m_ready = 1'b1;
        end else begin
          bus.m_ready = 1'b0;
          cnt++;
        end
      end else begin
        bus.m_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Completion and command monitor.
  initial begin : monitor
    bit prev_valid;
    bit prev_req;
    mem_cmd_t cur;
    rsp_t r;
    prev_valid = 1'b0;
    prev_req   = 1'b0;
    cur        = '0;
    forever begin
      @(negedge clk);
      if (bus.if_valid || bus.d_valid) begin
        check("valid_one_cycle", 128'(prev_valid), 128'(0));
        if (rsp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual if_valid=%0b d_valid=%0b required none", bus.if_valid, bus.d_valid);
        end else begin
          r = rsp_q.pop_front();
          check("valid_port", {127'(0), bus.d_valid}, {127'(0), (r.port == GNT_D)});
          if (r.port == GNT_I) check("if_rdata", 128'(bus.if_rdata), 128'(r.rdata));
          else                 check("d_rdata", 128'(bus.d_rdata), 128'(r.rdata));
        end
        rsp_seen++;
      end
      prev_valid = bus.if_valid || bus.d_valid;

      if (bus.m_req) begin
        if (!prev_req) begin
          if (cmd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_m_req actual addr=0x%0h required none", bus.m_addr);
          end else begin
            cur = cmd_q.pop_front();
          end
        end
        check("m_cmd", 128'({bus.m_we, bus.m_width, bus.m_addr, bus.m_wdata}), 128'(cur));
      end else begin
        check("m_we_idle", 128'(bus.m_we), 128'(0));
      end
      prev_req = bus.m_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int target, input int max_cyc, output int lat);
    lat = 0;
    while (rsp_seen < target && lat < max_cyc) begin
      tick();
      lat++;
    end
    if (rsp_seen < target) begin
      checks++;
      failures++;
      $display("FAIL wait_rsp timeout seen=%0d required=%0d", rsp_seen, target);
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] rdata, input int wt, output int lat);
    cmd_q.push_back('{we: 1'b0, width: WIDTH_WORD, addr: addr, wdata: exp_wdata});
    rsp_q.push_back('{port: GNT_I, rdata: rdata});
    resp_wait   = wt;
    bus.m_rdata = rdata;
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
    wait_rsp(rsp_seen + 1, 100, lat);
    bus.if_req  = 1'b0;
  endtask

  task automatic data(input logic we, input logic [1:0] width, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int wt,
                      output int lat);
    cmd_q.push_back('{we: we, width: width, addr: addr, wdata: wdata});
    rsp_q.push_back('{port: GNT_D, rdata: rdata});
    exp_wdata   = wdata;
    resp_wait   = wt;
    bus.m_rdata = rdata;
    bus.d_we    = we;
    bus.d_width = width;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_req   = 1'b1;
    wait_rsp(rsp_seen + 1, 100, lat);
    bus.d_req   = 1'b0;
  endtask

  initial begin : stimulus
    int lat;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_width = WIDTH_BYTE;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    bus.m_rdata = 32'h0;

    // Reset values.
    #1 rst_n = 1'b0;
    #2;
    check("rst_m_req_we", 128'({bus.m_req, bus.m_we}), 128'(0));
    check("rst_m_cmd", 128'({bus.m_width, bus.m_addr, bus.m_wdata}), 128'(0));
    check("rst_valids", 128'({bus.if_valid, bus.d_valid}), 128'(0));
    check("rst_rdata", 128'({bus.if_rdata, bus.d_rdata}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single fetch with m_ready tied high; stray ready while idle does nothing.
    stray = 1'b1;
    fetch(32'h0000_0200, 32'h0000_0013, 0, lat);
    check("fetch_latency", 128'(lat), 128'(3));
    repeat (4) begin
      tick();
      check("stray_idle", 128'({bus.m_req, bus.if_valid, bus.d_valid}), 128'(0));
    end
    stray = 1'b0;

    // Byte load; fetch data must be left alone.
    data(1'b0, WIDTH_BYTE, 32'h0000_0101, 32'h0, 32'h0000_00AB, 0, lat);
    check("load_latency", 128'(lat), 128'(3));
    check("if_rdata_hold", 128'(bus.if_rdata), 128'(32'h0000_0013));

    // Word store with five wait states: six BUSY_D cycles.
    data(1'b1, WIDTH_WORD, 32'h0000_03FC, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5, lat);
    check("store_latency", 128'(lat), 128'(8));
    check("d_rdata_hold", 128'(bus.d_rdata), 128'(32'hCAFE_F00D));

    // Both held: grants alternate I, D, I, D starting with I (last was D).
    cmd_q.push_back('{we: 1'b0, width: WIDTH_WORD, addr: 32'h0000_0100, wdata: 32'hDEAD_BEEF});
    cmd_q.push_back('{we: 1'b0, width: WIDTH_HALF, addr: 32'h0000_0402, wdata: 32'h55AA_55AA});
    cmd_q.push_back('{we: 1'b0, width: WIDTH_WORD, addr: 32'h0000_0100, wdata: 32'h55AA_55AA});
    cmd_q.push_back('{we: 1'b0, width: WIDTH_HALF, addr: 32'h0000_0402, wdata: 32'h55AA_55AA});
    rsp_q.push_back('{port: GNT_I, rdata: 32'h0BAD_F00D});
    rsp_q.push_back('{port: GNT_D, rdata: 32'h0BAD_F00D});
    rsp_q.push_back('{port: GNT_I, rdata: 32'h0BAD_F00D});
    rsp_q.push_back('{port: GNT_D, rdata: 32'h0BAD_F00D});
    exp_wdata   = 32'h55AA_55AA;
    resp_wait   = 1;
    bus.m_rdata = 32'h0BAD_F00D;
    bus.if_addr = 32'h0000_0100;
    bus.d_we    = 1'b0;
    bus.d_width = WIDTH_HALF;
    bus.d_addr  = 32'h0000_0402;
    bus.d_wdata = 32'h55AA_55AA;
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    wait_rsp(rsp_seen + 4, 200, lat);
    check("tie_total_cycles", 128'(lat), 128'(16));
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;

    // Fetch with two wait states leaves last grant on I.
    fetch(32'h0000_0300, 32'h0000_0022, 2, lat);
    check("fetch_wait_latency", 128'(lat), 128'(5));

    // Reset mid-BUSY_D.
    cmd_q.push_back('{we: 1'b1, width: WIDTH_WORD, addr: 32'h0000_0080, wdata: 32'h1234_5678});
    resp_wait   = 50;
    bus.d_we    = 1'b1;
    bus.d_width = WIDTH_WORD;
    bus.d_addr  = 32'h0000_0080;
    bus.d_wdata = 32'h1234_5678;
    bus.d_req   = 1'b1;
    repeat (3) tick();
    check("busy_before_rst", 128'({bus.m_req, bus.m_we}), 128'(2'b11));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_m_req_valid", 128'({bus.m_req, bus.d_valid, bus.if_valid, bus.m_we}), 128'(0));
    check("mid_rst_m_cmd", 128'({bus.m_width, bus.m_addr, bus.m_wdata}), 128'(0));
    check("mid_rst_rdata", 128'({bus.if_rdata, bus.d_rdata}), 128'(0));
    rsp_q.delete();
    cmd_q.delete();
    exp_wdata = 32'h0;
    bus.d_req = 1'b0;

    // After release both request at once: fetch must win the first tie.
    @(negedge clk);
    rst_n = 1'b1;
    cmd_q.push_back('{we: 1'b0, width: WIDTH_WORD, addr: 32'h0000_0600, wdata: 32'h0});
    cmd_q.push_back('{we: 1'b0, width: WIDTH_WORD, addr: 32'h0000_0700, wdata: 32'h0000_0077});
    rsp_q.push_back('{port: GNT_I, rdata: 32'h0000_0066});
    rsp_q.push_back('{port: GNT_D, rdata: 32'h0000_0066});
    resp_wait   = 0;
    bus.m_rdata = 32'h0000_0066;
    bus.if_addr = 32'h0000_0600;
    bus.d_we    = 1'b0;
    bus.d_width = WIDTH_WORD;
    bus.d_addr  = 32'h0000_0700;
    bus.d_wdata = 32'h0000_0077;
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    tick();
    check("post_rst_m_req", 128'(bus.m_req), 128'(1));
    check("post_rst_m_addr", 128'(bus.m_addr), 128'(32'h0000_0600));
    wait_rsp(rsp_seen + 2, 50, lat);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;

    repeat (4) tick();
    check("rsp_q_drained", 128'(rsp_q.size()), 128'(0));
    check("cmd_q_drained", 128'(cmd_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clk and rst_n are the port names.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 if_req  in  1  instruction-fetch request; held with if_addr stable until if_valid.
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_rdata  out  32  fetched word.
REQ-007 if_valid  out  1  one-cycle fetch completion pulse.
REQ-008 d_req  in  1  data request; held with d_we/d_width/d_addr/d_wdata stable until d_valid.
REQ-009 d_we  in  1  1 = store, 0 = load.
REQ-010 d_width  in  2  access width code (funct3[1:0]).
REQ-011 d_addr  in  32  data address.
REQ-012 d_wdata  in  32  store data.
REQ-013 d_rdata  out  32  load data.
REQ-014 d_valid  out  1  one-cycle data completion pulse.
REQ-015 m_req  out  1  memory request; m_addr/m_we/m_width/m_wdata are valid while it is high.
REQ-016 m_we, m_width, m_addr, m_wdata  out  1/2/32/32  shared memory command.
REQ-017 m_rdata  in  32  memory read data, sampled when m_ready = 1.
REQ-018 m_ready  in  1  memory completion; ignored unless m_req = 1.

Function
REQ-019 The FSM SHALL have the states IDLE, BUSY_I, BUSY_D and DONE.
REQ-020 IDLE: with no requests, stay in IDLE.
  - if_req alone -> BUSY_I; d_req alone -> BUSY_D.
  - Both requests -> grant the port not granted last (round-robin).
REQ-021 On the IDLE->BUSY transition, the command SHALL be registered into m_addr/m_we/m_width/m_wdata.
  - Fetch: m_we = 0, m_width = 2'b10, m_wdata unchanged.
  - Data: d_we/d_width/d_addr/d_wdata are copied as-is.
REQ-022 m_req SHALL be 1 exactly in BUSY_I/BUSY_D; m_we SHALL be 0 outside BUSY_D.
REQ-023 In BUSY_x with m_ready = 1, the FSM SHALL go to DONE.
  - Capture m_rdata into x_rdata, even for stores.
  - Set last_grant = x.
REQ-024 In BUSY_x with m_ready = 0, the FSM SHALL stay in BUSY_x with the command unchanged, for an unbounded wait.
REQ-025 DONE SHALL assert x_valid for exactly one cycle, ignore all requests, then go to IDLE.
REQ-026 Latency: request sampled at edge E -> m_req high from E+1 -> m_ready at edge E+k (k >= 1) -> x_valid high in cycle E+k to E+k+1. The minimum is 3 cycles per transaction.
REQ-027 A requester that keeps x_req high after x_valid SHALL be treated as a new request at the next IDLE.
REQ-028 if_rdata/d_rdata SHALL hold their value until the next completion on their own port.
REQ-029 A request dropped mid-BUSY is a protocol violation; the transaction SHALL still complete and pulse valid.

Reset
REQ-030 rst_n = 0 SHALL asynchronously force the following, abandoning any in-flight transaction:
  - state = IDLE and last_grant = D, so the fetch wins the first tie;
  - m_req = m_we = 0 and m_width = m_addr = m_wdata = 0;
  - if_valid = d_valid = 0 and if_rdata = d_rdata = 0.
REQ-031 After rst_n rises, the first request SHALL be sampled at the first clk edge.

Structure
REQ-032 A shared package SHALL hold:
  - the state encoding (2 bits);
  - the grant IDs GNT_I/GNT_D;
  - the width codes (BYTE = 00, HALF = 01, WORD = 10).
REQ-033 Two-way round-robin selection SHALL be a sub-module, rr_arb2.
  - Inputs: req[1:0] and last_grant.
  - Output: one-hot gnt.
  - Purely combinational.

Verification
REQ-034 Reset: assert rst_n = 0 mid-BUSY_D -> m_req = 0, d_valid = 0, state IDLE immediately. After release, if_req = 1 -> m_req high 1 cycle later with m_addr = if_addr.
REQ-035 Single fetch: if_addr = 0x200, m_ready tied 1, m_rdata = 0x00000013 -> if_valid pulses once in cycle 3, if_rdata = 0x00000013, m_width = 2'b10, m_we = 0.
REQ-036 Tie after reset: if_req = d_req = 1 held -> grants alternate I, D, I, D; each valid is 1 cycle.
REQ-037 Store with wait states: d_we = 1, d_addr = 0x3FC, d_wdata = 0xDEADBEEF, d_width = 2'b10, m_ready low for 5 cycles -> command stable for all 6 BUSY_D cycles, then d_valid pulses.
REQ-038 Load: d_width = 2'b00, m_rdata = 0x000000AB -> d_rdata = 0x000000AB; if_rdata unchanged.
REQ-039 Stray m_ready = 1 while IDLE/DONE -> no valid pulse, no state change.
